// File: rtl/gena_poly_writer_pkg.sv
// Shared constants, FSM state encoding and RAM address helper for the matrix-A writer.
// Contents: K, WORDS_PER_POLY, ADDR_W, COEF_W, KYBER_Q, state_t, poly_base().
// The RAM holds polynomials back to back, WORDS_PER_POLY pair-words each.
package gena_poly_writer_pkg;

  localparam int K              = 3;
  localparam int WORDS_PER_POLY = 128;
  localparam int ADDR_W         = 11;
  localparam int COEF_W         = 12;
  localparam logic [COEF_W-1:0] KYBER_Q = 12'hD01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_NEXT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // First RAM word of a polynomial; the product always fits ADDR_W bits.
  function automatic logic [ADDR_W-1:0] poly_base(input logic [3:0] poly_idx);
    return ADDR_W'(poly_idx) * ADDR_W'(WORDS_PER_POLY);
  endfunction

endpackage

// File: rtl/gena_poly_writer_index_ctr.sv
// Matrix (row, col) counter for the KxK polynomial sweep, with last-polynomial flag.
// Ports: clr/adv step the counter; transpose swaps the index roles; poly_idx/row_i/col_j/last
// are combinational views of the registered i/j pair.
module gena_index_ctr
  import gena_poly_writer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  input  logic       transpose,
  output logic [3:0] poly_idx,
  output logic [1:0] row_i,
  output logic [1:0] col_j,
  output logic       last
);

  logic [1:0] i_q;
  logic [1:0] j_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q <= '0;
      j_q <= '0;
    end else if (clr) begin
      i_q <= '0;
      j_q <= '0;
    end else if (adv) begin
      if (j_q == 2'(K-1)) begin
        j_q <= '0;
        i_q <= i_q + 2'd1;
      end else begin
        j_q <= j_q + 2'd1;
      end
    end
  end

  // The sweep order is always i-major; transpose only changes where each
  // polynomial lands and how the indices are reported.
  always_comb begin
    poly_idx = transpose ? (4'(j_q) * 4'(K) + 4'(i_q))
                         : (4'(i_q) * 4'(K) + 4'(j_q));
    row_i    = transpose ? j_q : i_q;
    col_j    = transpose ? i_q : j_q;
    last     = (i_q == 2'(K-1)) && (j_q == 2'(K-1));
  end

endmodule

// File: rtl/gena_poly_writer.sv
// Drains the hash server's sampled-coefficient FIFO into the matrix-A RAM, K*K polys of 128 words.
// Ports: start/busy/done control; fifo_empty/fifo_req/fifo_dout (data one cycle after req);
// row_i/col_j/next_poly to the absorb controller; ram_we/ram_addr/ram_din write port (never stalls).
// Latency: RAM write one cycle after each accepted fifo_req; 130 cycles per poly with a full FIFO.
// Optional macro TRANSPOSE_EN adds the transpose input (sampled on start) to build A^T.
module gena_poly_writer
  import gena_poly_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef TRANSPOSE_EN
  input  logic              transpose,
`endif
  output logic              busy,
  output logic              done,
  input  logic              fifo_empty,
  output logic              fifo_req,
  input  logic [2*COEF_W-1:0] fifo_dout,
  output logic [1:0]        row_i,
  output logic [1:0]        col_j,
  output logic              next_poly,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [2*COEF_W-1:0] ram_din
);

  localparam int CTR_W = $clog2(WORDS_PER_POLY + 1);

  state_t           state;
  logic [CTR_W-1:0] req_ctr;
  logic [CTR_W-1:0] wr_ctr;
  logic             req_r1;
  logic             tr_q;
  logic [3:0]       poly_idx;
  logic             last;
  logic             idx_clr;
  logic             idx_adv;

`ifdef TRANSPOSE_EN
  // Held for the whole run so a toggling input cannot split the matrix layout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tr_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      tr_q <= transpose;
    end
  end
`else
  assign tr_q = 1'b0;
`endif

  gena_index_ctr u_index_ctr (
    .clk       (clk),
    .rst       (rst),
    .clr       (idx_clr),
    .adv       (idx_adv),
    .transpose (tr_q),
    .poly_idx  (poly_idx),
    .row_i     (row_i),
    .col_j     (col_j),
    .last      (last)
  );

  assign idx_clr = (state == S_DONE);
  assign idx_adv = (state == S_NEXT) && !last;

  // Combinational with fifo_empty so a request is never made against an empty FIFO.
  assign fifo_req = (state == S_RUN) && !fifo_empty && (req_ctr < CTR_W'(WORDS_PER_POLY));

  // FIFO read data arrives in the cycle after the request, aligned with req_r1.
  assign ram_we   = req_r1;
  assign ram_din  = req_r1 ? fifo_dout : '0;
  assign ram_addr = poly_base(poly_idx) + ADDR_W'(wr_ctr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      next_poly <= 1'b0;
      req_r1    <= 1'b0;
      req_ctr   <= '0;
      wr_ctr    <= '0;
    end else begin
      done      <= 1'b0;
      next_poly <= 1'b0;
      req_r1    <= fifo_req;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            req_ctr <= '0;
            wr_ctr  <= '0;
          end
        end
        S_RUN: begin
          if (fifo_req) begin
            req_ctr <= req_ctr + 1'b1;
          end
          if (ram_we) begin
            wr_ctr <= wr_ctr + 1'b1;
            if (wr_ctr == CTR_W'(WORDS_PER_POLY - 1)) begin
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          req_ctr <= '0;
          wr_ctr  <= '0;
          if (last) begin
            state <= S_DONE;
          end else begin
            next_poly <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
